// File: rtl/signal_capture.sv
// signal_capture: multi-channel waveform capture buffer with decimation, rolling or
//   triggered single-shot recording with pretrigger, and oldest-first readout.
// Latency: an accepted sample is stored on the edge of its strobe; rd_data follows rd_addr by 2 cycles.
// Backpressure: none; strobes are never stalled, they are simply not stored in IDLE, DONE or frozen RUN.
//
// Optional feature macro: SIGNAL_CAPTURE_PEAK_EN -- store (and trigger on) the per-channel
//   maximum of each decimation window instead of the sample on the accepted strobe.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   sample_en/sample_in one-cycle sample strobe and packed samples (channel 0 in LSBs)
//   decim               keep 1 of every decim strobes (0 and 1 keep every strobe)
//   mode, arm, freeze   0 = rolling / 1 = triggered; arm starts a capture; freeze holds rolling writes
//   trig_level/falling  channel-0 threshold and slope select
//   rd_addr/rd_data     logical read index (0 = oldest) and read data
//   state, done, wr_ptr FSM state, capture complete, next physical write address
module signal_capture #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int DECIM_W  = 16,
  parameter int PRETRIG  = 256
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sample_en,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  input  logic [DECIM_W-1:0]        decim,
  input  logic                      mode,
  input  logic                      arm,
  input  logic                      freeze,
  input  logic [WIDTH-1:0]          trig_level,
  input  logic                      trig_falling,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [CHANNELS*WIDTH-1:0] rd_data,
  output logic [2:0]                state,
  output logic                      done,
  output logic [ADDR_W-1:0]         wr_ptr
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PRE  = 3'd2,
    ST_WAIT = 3'd3,
    ST_POST = 3'd4,
    ST_DONE = 3'd5
  } cap_state_t;

  localparam int DW = CHANNELS * WIDTH;
  // Counter values on the last pretrigger write and on the last post-trigger write.
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRETRIG - 2);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);

  cap_state_t          cur_st, nxt_st;
  logic [DW-1:0]       mem [DEPTH];
  logic [ADDR_W-1:0]   start_ptr, rd_phys, pre_cnt, post_cnt;
  logic [DECIM_W-1:0]  dcnt, dmax;
  logic [WIDTH-1:0]    prev, cur0;
  logic [DW-1:0]       wdat;
  logic                accept, cnt_clr, wr_en, crossing, trig_fire;

  assign dmax = (decim == '0) ? DECIM_W'(1) : decim;
  // '>=' rather than '==' so a decim lowered mid-window wraps at once instead of
  // running the counter all the way round.
  assign accept = sample_en && (dcnt >= dmax - DECIM_W'(1));

`ifdef SIGNAL_CAPTURE_PEAK_EN
  logic [DW-1:0] pk_q;  // per-channel max of the earlier strobes of this window

  always_comb begin
    wdat = sample_in;
    for (int c = 0; c < CHANNELS; c++) begin
      if (pk_q[c*WIDTH +: WIDTH] > sample_in[c*WIDTH +: WIDTH]) begin
        wdat[c*WIDTH +: WIDTH] = pk_q[c*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || cnt_clr) begin
      pk_q <= '0;
    end else if (sample_en) begin
      pk_q <= accept ? '0 : wdat;
    end
  end
`else
  assign wdat = sample_in;
`endif

  assign cur0 = wdat[WIDTH-1:0];
  assign crossing = trig_falling ? ((prev > trig_level) && (cur0 <= trig_level))
                                 : ((prev < trig_level) && (cur0 >= trig_level));

  always_comb begin
    nxt_st = cur_st;
    wr_en  = 1'b0;
    case (cur_st)
      ST_IDLE: begin
        if (!mode) nxt_st = ST_RUN;
        else if (arm) nxt_st = ST_PRE;
      end
      ST_RUN: begin
        wr_en = accept && !freeze;
        if (mode) nxt_st = ST_IDLE;
      end
      ST_PRE: begin
        wr_en = accept;
        if (!mode) nxt_st = ST_IDLE;
        else if (accept && (pre_cnt == PRE_LAST)) nxt_st = ST_WAIT;
      end
      ST_WAIT: begin
        wr_en = accept;
        if (!mode) nxt_st = ST_IDLE;
        else if (accept && crossing) nxt_st = ST_POST;
      end
      ST_POST: begin
        wr_en = accept;
        if (!mode) nxt_st = ST_IDLE;
        else if (accept && (post_cnt == POST_LAST)) nxt_st = ST_DONE;
      end
      ST_DONE: begin
        if (!mode) nxt_st = ST_IDLE;
        else if (arm) nxt_st = ST_PRE;
      end
      default: nxt_st = ST_IDLE;
    endcase
  end

  assign cnt_clr   = (nxt_st != cur_st) && ((nxt_st == ST_PRE) || (nxt_st == ST_RUN));
  assign trig_fire = (cur_st == ST_WAIT) && (nxt_st == ST_POST);

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_st    <= ST_IDLE;
      wr_ptr    <= '0;
      start_ptr <= '0;
      dcnt      <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      prev      <= '0;
      rd_phys   <= '0;
    end else begin
      cur_st <= nxt_st;

      if (cnt_clr) dcnt <= '0;
      else if (sample_en) dcnt <= accept ? '0 : dcnt + 1'b1;

      if (wr_en) wr_ptr <= wr_ptr + 1'b1;

      // In RUN the oldest sample is always the one about to be overwritten.
      if (cur_st == ST_RUN) start_ptr <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
      else if (nxt_st == ST_RUN) start_ptr <= wr_ptr;
      else if (trig_fire) start_ptr <= wr_ptr - PRE_OFS;

      if (cnt_clr && (nxt_st == ST_PRE)) pre_cnt <= '0;
      else if ((cur_st == ST_PRE) && accept) pre_cnt <= pre_cnt + 1'b1;

      if (trig_fire) post_cnt <= '0;
      else if ((cur_st == ST_POST) && accept) post_cnt <= post_cnt + 1'b1;

      if (((cur_st == ST_PRE) || (cur_st == ST_WAIT)) && accept) prev <= cur0;

      rd_phys <= start_ptr + rd_addr;
    end
  end

  // Sample memory: no reset, read-before-write on a same-address collision.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem[wr_ptr] <= wdat;
  end

  always_ff @(posedge clock) begin
    if (reset) rd_data <= '0;
    else rd_data <= mem[rd_phys];
  end

  assign state = cur_st;
  assign done  = (cur_st == ST_DONE);

endmodule

// File: tb/tb_signal_capture.sv
// tb_signal_capture: self-checking bench for signal_capture (default parameters).
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: none; strobes are driven freely.
module tb_signal_capture;

  localparam int WIDTH = 8, CHANNELS = 2, DEPTH = 1024, ADDR_W = 10, DECIM_W = 16, PRETRIG = 256;

  logic                      clock = 1'b0;
  logic                      reset, sample_en, mode, arm, freeze, trig_falling;
  logic [CHANNELS*WIDTH-1:0] sample_in, rd_data;
  logic [DECIM_W-1:0]        decim;
  logic [WIDTH-1:0]          trig_level;
  logic [ADDR_W-1:0]         rd_addr, wr_ptr;
  logic [2:0]                state;
  logic                      done;

  int checks = 0;
  int errors = 0;

  signal_capture #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .DECIM_W(DECIM_W), .PRETRIG(PRETRIG)
  ) dut (
    .clock(clock), .reset(reset), .sample_en(sample_en), .sample_in(sample_in),
    .decim(decim), .mode(mode), .arm(arm), .freeze(freeze), .trig_level(trig_level),
    .trig_falling(trig_falling), .rd_addr(rd_addr), .rd_data(rd_data), .state(state),
    .done(done), .wr_ptr(wr_ptr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       md;
    logic       ar;
    logic       se;
    logic [2:0] st;
    int         wp;
  } vec_t;

  vec_t vt[14];
  logic [15:0] win[$];
  logic [15:0] hist[$];
  logic [15:0] acc[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input logic [7:0] c0, input logic [7:0] c1);
    sample_en = 1'b1;
    sample_in = {c1, c0};
    tick();
    sample_en = 1'b0;
  endtask

  task automatic chk_rd(input string name, input int a, input logic [15:0] exp);
    rd_addr = ADDR_W'(a);
    tick();
    tick();
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_en = 1'b0; arm = 1'b0; mode = 1'b1; freeze = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] ramp(input int i);
    return {8'(i * 3), 8'(i)};
  endfunction

  // Value stored for a completed decimation window.
  function automatic logic [15:0] model_val(input logic [15:0] w[$]);
    logic [15:0] r;
`ifdef SIGNAL_CAPTURE_PEAK_EN
    r = '0;
    foreach (w[j]) begin
      logic [15:0] s;
      s = w[j];
      if (s[7:0] > r[7:0]) r[7:0] = s[7:0];
      if (s[15:8] > r[15:8]) r[15:8] = s[15:8];
    end
`else
    r = w[w.size()-1];
`endif
    return r;
  endfunction

  function automatic bit model_cross(input logic [7:0] p, input logic [7:0] c,
                                     input logic [7:0] lvl, input logic fall);
    if (fall) return (p > lvl) && (c <= lvl);
    return (p < lvl) && (c >= lvl);
  endfunction

  initial begin
    logic [15:0] pk_exp;
    int d, k, a, lo;
    bit fin;

    reset = 1'b1; sample_en = 1'b0; sample_in = '0; decim = 16'd1; mode = 1'b1; arm = 1'b0;
    freeze = 1'b0; trig_level = 8'd100; trig_falling = 1'b0; rd_addr = '0;

    // Reset state
    tick();
    tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_wr_ptr", 32'(wr_ptr), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_data", 32'(rd_data), 0);

    // FSM transition table: {reset, mode, arm, sample_en} -> {state, wr_ptr}
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 0};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1};
    vt[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 2};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2};
    vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 0};
    for (int i = 0; i < 14; i++) begin
      reset = vt[i].rst; mode = vt[i].md; arm = vt[i].ar; sample_en = vt[i].se;
      sample_in = 16'($urandom);
      tick();
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].st));
      chk($sformatf("vec%0d_wr_ptr", i), 32'(wr_ptr), 32'(vt[i].wp));
    end
    reset = 1'b0; arm = 1'b0; sample_en = 1'b0;

    // Rolling capture, 1030-sample ramp
    do_reset();
    mode = 1'b0; decim = 16'd1;
    tick();
    chk("roll_state", 32'(state), 1);
    for (int i = 0; i < 1030; i++) push(8'(i), 8'(i * 3));
    chk("roll_wr_ptr", 32'(wr_ptr), 6);
    chk_rd("roll_rd0", 0, ramp(6));
    rd_addr = 10'd1023;
    tick();
    chk("roll_rd_latency", 32'(rd_data), 32'(ramp(6)));
    tick();
    chk("roll_rd1023", 32'(rd_data), 32'(ramp(1029)));
    chk_rd("roll_rd512", 512, ramp(518));
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) push(8'd1, 8'd1);
    chk("freeze_wr_ptr", 32'(wr_ptr), 6);
    freeze = 1'b0;
    push(8'd77, 8'd66);
    chk("unfreeze_wr_ptr", 32'(wr_ptr), 7);
    chk_rd("unfreeze_newest", 1023, 16'h4240 + 16'h000D);

    // Decimation by 4
    do_reset();
    mode = 1'b0; decim = 16'd4;
    tick();
    for (int i = 0; i < 16; i++) push(8'(i), 8'd0);
    chk("decim_wr_ptr", 32'(wr_ptr), 4);
    for (int j = 0; j < 4; j++) chk_rd($sformatf("decim_phys%0d", j), 1020 + j, 16'(4 * j + 3));

    // Rising trigger
    do_reset();
    decim = 16'd1; trig_level = 8'd100; trig_falling = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("trig_pre", 32'(state), 2);
    for (int i = 0; i < 256; i++) push(8'd0, 8'(i));
    chk("trig_wait", 32'(state), 3);
    for (int i = 0; i < 44; i++) push(8'd0, 8'(i));
    chk("trig_still_wait", 32'(state), 3);
    push(8'd200, 8'd1);
    chk("trig_post", 32'(state), 4);
    for (int i = 0; i < 766; i++) push(8'd200, 8'd2);
    chk("trig_post_last", 32'(state), 4);
    chk("trig_not_done", 32'(done), 0);
    push(8'd200, 8'd3);
    chk("trig_done_state", 32'(state), 5);
    chk("trig_done", 32'(done), 1);
    chk("trig_wr_ptr", 32'(wr_ptr), 44);
    push(8'd9, 8'd9);
    chk("done_no_write", 32'(wr_ptr), 44);
    chk_rd("trig_rd255", 255, 16'h2B00);
    chk_rd("trig_rd256", 256, 16'h01C8);
    chk_rd("trig_rd0", 0, 16'h2C00);
    chk_rd("trig_rd1023", 1023, 16'h03C8);

    // Pretrigger blanking: rearm from DONE, step inside the pretrigger window
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("blank_pre", 32'(state), 2);
    chk("blank_done_clr", 32'(done), 0);
    for (int i = 0; i < 10; i++) push(8'd0, 8'd0);
    for (int i = 0; i < 246; i++) push(8'd200, 8'd0);
    chk("blank_wait", 32'(state), 3);
    for (int i = 0; i < 5; i++) push(8'd200, 8'd0);
    push(8'd50, 8'd0);
    chk("blank_no_trig", 32'(state), 3);
    push(8'd150, 8'd0);
    chk("blank_post", 32'(state), 4);
    for (int i = 0; i < 767; i++) push(8'd150, 8'd0);
    chk("blank_done", 32'(done), 1);
    chk_rd("blank_rd256", 256, 16'd150);
    chk_rd("blank_rd255", 255, 16'd50);

    // Mid-capture control
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 256; i++) push(8'd0, 8'd0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_in_wait", 32'(state), 3);
    mode = 1'b0;
    tick();
    chk("wait_mode0_idle", 32'(state), 0);
    tick();
    chk("wait_mode0_run", 32'(state), 1);
    mode = 1'b1;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 256; i++) push(8'd0, 8'd0);
    push(8'd200, 8'd0);
    for (int i = 0; i < 10; i++) push(8'd200, 8'd0);
    chk("post_before_reset", 32'(state), 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_reset_state", 32'(state), 0);
    chk("post_reset_done", 32'(done), 0);
    chk("post_reset_wr_ptr", 32'(wr_ptr), 0);

    // Peak / decimated window
    do_reset();
    mode = 1'b0; decim = 16'd4;
    tick();
    push(8'd5, 8'd8); push(8'd9, 8'd2); push(8'd2, 8'd6); push(8'd1, 8'd4);
`ifdef SIGNAL_CAPTURE_PEAK_EN
    pk_exp = 16'h0809;
`else
    pk_exp = 16'h0401;
`endif
    chk("peak_wr_ptr", 32'(wr_ptr), 1);
    chk_rd("peak_value", 1023, pk_exp);

    // Randomized rolling run against the history model
    do_reset();
    d = $urandom_range(0, 3);
    mode = 1'b0; decim = 16'(d);
    if (d == 0) d = 1;
    tick();
    win.delete();
    hist.delete();
    for (int c = 0; c < 4000; c++) begin
      sample_en = ($urandom_range(0, 9) < 8);
      freeze = ($urandom_range(0, 9) == 0);
      sample_in = 16'($urandom);
      if (sample_en) begin
        win.push_back(sample_in);
        if (win.size() == d) begin
          if (!freeze) hist.push_back(model_val(win));
          win.delete();
        end
      end
      tick();
    end
    sample_en = 1'b0; freeze = 1'b0;
    chk("rand_roll_wr_ptr", 32'(wr_ptr), 32'(hist.size() % DEPTH));
    lo = (hist.size() >= DEPTH) ? 0 : DEPTH - hist.size();
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(lo, DEPTH - 1);
      chk_rd($sformatf("rand_roll_rd%0d", a), a, hist[hist.size() - DEPTH + a]);
    end

    // Randomized triggered capture against the accepted-sample model
    do_reset();
    d = $urandom_range(1, 2);
    decim = 16'(d);
    trig_falling = 1'($urandom_range(0, 1));
    trig_level = 8'($urandom_range(60, 190));
    arm = 1'b1;
    tick();
    arm = 1'b0;
    win.delete();
    acc.delete();
    k = -1;
    fin = 1'b0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      sample_en = ($urandom_range(0, 9) < 8);
      sample_in = 16'($urandom);
      if (sample_en) begin
        win.push_back(sample_in);
        if (win.size() == d) begin
          logic [15:0] pv, cv;
          acc.push_back(model_val(win));
          win.delete();
          if (k < 0 && acc.size() > PRETRIG) begin
            pv = acc[acc.size() - 2];
            cv = acc[acc.size() - 1];
            if (model_cross(pv[7:0], cv[7:0], trig_level, trig_falling)) k = acc.size() - 1;
          end
        end
      end
      tick();
      if (k >= 0 && acc.size() == k + DEPTH - PRETRIG) fin = 1'b1;
    end
    sample_en = 1'b0;
    chk("rand_trig_finished", 32'(fin), 1);
    if (fin) begin
      chk("rand_trig_done", 32'(done), 1);
      chk("rand_trig_wr_ptr", 32'(wr_ptr), 32'(acc.size() % DEPTH));
      chk_rd("rand_trig_at", PRETRIG, acc[k]);
      for (int i = 0; i < 10; i++) begin
        a = $urandom_range(0, DEPTH - 1);
        chk_rd($sformatf("rand_trig_rd%0d", a), a, acc[k - PRETRIG + a]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
